// File: rtl/state_screen_renderer.sv
//------------------------------------------------------------------------------
// Module      : state_screen_renderer
// Description : Per-game-state pixel colour generator placed between the snake
//               control logic and the VGA output stage. Each state has its own
//               screen (Idle solid, Play passthrough, Win moving diamond, Lose
//               flashing). A Play_State change starts a top-down wipe from the
//               old screen to the new one. All animation advances on a single
//               end-of-frame tick taken from the scan coordinates.
// Ports       : CLK         in   pixel clock
//               RESET       in   synchronous active-high reset
//               X, Y        in   current pixel column / row
//               Play_State  in   00 Idle, 01 Play, 10 Win, 11 Lose
//               Colour_in   in   Play-state pixel colour
//               Colour      out  registered pixel colour (1 cycle latency)
//               Frame_Tick  out  registered one-cycle pulse per frame
//               Wipe_Active out  high while a transition wipe is running
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module state_screen_renderer #(
  parameter int                    H_RES        = 640,
  parameter int                    V_RES        = 480,
  parameter int                    X_W          = 10,
  parameter int                    Y_W          = 9,
  parameter int                    COLOUR_W     = 12,
  parameter int                    FRAME_W      = 16,
  parameter logic [COLOUR_W-1:0]   IDLE_COLOUR  = 12'hF00,
  parameter logic [COLOUR_W-1:0]   LOSE_COLOUR  = 12'h00F,
  parameter int                    FLASH_FRAMES = 16,
  parameter int                    WIPE_STEP    = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [X_W-1:0]      X,
  input  logic [Y_W-1:0]      Y,
  input  logic [1:0]          Play_State,
  input  logic [COLOUR_W-1:0] Colour_in,
  output logic [COLOUR_W-1:0] Colour,
  output logic                Frame_Tick,
  output logic                Wipe_Active
);

  // Win pattern sum is formed wide enough for both distances plus the
  // 8-bit frame slice, then truncated to the colour width.
  localparam int MAX_W = (X_W > Y_W) ? ((X_W > 8) ? X_W : 8)
                                     : ((Y_W > 8) ? Y_W : 8);
  localparam int SUM_W = MAX_W + 2;
  localparam int ROW_W = Y_W + 1;

  localparam logic [SUM_W-1:0] H_HALF      = SUM_W'(H_RES / 2);
  localparam logic [SUM_W-1:0] V_HALF      = SUM_W'(V_RES / 2);
  localparam logic [X_W-1:0]   X_LAST      = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]   Y_LAST      = Y_W'(V_RES - 1);
  localparam logic [ROW_W-1:0] ROW_STEP    = ROW_W'(WIPE_STEP);
  localparam logic [ROW_W-1:0] ROW_LIMIT   = ROW_W'(V_RES);
  localparam logic [FRAME_W-1:0] FLASH_LAST = FRAME_W'(FLASH_FRAMES - 1);

  typedef enum logic [0:0] {
    WIPE_IDLE = 1'b0,
    WIPING    = 1'b1
  } wipe_state_e;

  // Registered state
  logic [COLOUR_W-1:0] colour_q,      colour_d;
  logic                frame_tick_q,  frame_tick_d;
  logic                wipe_active_q, wipe_active_d;
  logic [FRAME_W-1:0]  frame_count_q, frame_count_d;
  logic [FRAME_W-1:0]  flash_cnt_q,   flash_cnt_d;
  logic                flash_on_q,    flash_on_d;
  logic [1:0]          cur_state_q,   cur_state_d;
  logic [1:0]          old_state_q,   old_state_d;
  logic [ROW_W-1:0]    wipe_row_q,    wipe_row_d;
  wipe_state_e         wipe_state_q,  wipe_state_d;

  // Combinational helpers
  logic                tick_w;
  logic                change_w;
  logic [ROW_W-1:0]    next_row_w;
  logic [SUM_W-1:0]    x_ext_w, y_ext_w, dx_w, dy_w, win_sum_w;
  logic [COLOUR_W-1:0] win_colour_w;
  logic [COLOUR_W-1:0] lose_colour_w;
  logic [COLOUR_W-1:0] new_colour_w;
  logic [COLOUR_W-1:0] old_colour_w;

  function automatic logic [COLOUR_W-1:0] screen_colour(
    input logic [1:0]          st,
    input logic [COLOUR_W-1:0] play_c,
    input logic [COLOUR_W-1:0] win_c,
    input logic [COLOUR_W-1:0] lose_c
  );
    logic [COLOUR_W-1:0] c;
    case (st)
      2'b00:   c = IDLE_COLOUR;
      2'b01:   c = play_c;
      2'b10:   c = win_c;
      default: c = lose_c;
    endcase
    return c;
  endfunction

  always_comb begin
    tick_w   = (X == X_LAST) && (Y == Y_LAST);
    change_w = (Play_State != cur_state_q);

    // Unsigned distances from screen centre
    x_ext_w   = SUM_W'(X);
    y_ext_w   = SUM_W'(Y);
    dx_w      = (x_ext_w >= H_HALF) ? (x_ext_w - H_HALF) : (H_HALF - x_ext_w);
    dy_w      = (y_ext_w >= V_HALF) ? (y_ext_w - V_HALF) : (V_HALF - y_ext_w);
    win_sum_w = dx_w + dy_w + SUM_W'(frame_count_q[FRAME_W-1 -: 8]);
    win_colour_w  = COLOUR_W'(win_sum_w);
    lose_colour_w = flash_on_q ? LOSE_COLOUR : '0;

    new_colour_w = screen_colour(Play_State, Colour_in, win_colour_w, lose_colour_w);
    old_colour_w = screen_colour(old_state_q, Colour_in, win_colour_w, lose_colour_w);

    next_row_w = wipe_row_q + ROW_STEP;

    // Defaults
    frame_tick_d  = tick_w;
    frame_count_d = frame_count_q;
    flash_cnt_d   = flash_cnt_q;
    flash_on_d    = flash_on_q;
    cur_state_d   = Play_State;
    old_state_d   = old_state_q;
    wipe_row_d    = wipe_row_q;
    wipe_state_d  = wipe_state_q;
    wipe_active_d = (wipe_state_q == WIPING);

    if (tick_w) begin
      frame_count_d = frame_count_q + FRAME_W'(1);
      if (flash_cnt_q == FLASH_LAST) begin
        flash_cnt_d = '0;
        flash_on_d  = ~flash_on_q;
      end else begin
        flash_cnt_d = flash_cnt_q + FRAME_W'(1);
      end
    end

    // A change always (re)starts the wipe, even on a tick cycle.
    if (change_w) begin
      wipe_state_d = WIPING;
      old_state_d  = cur_state_q;
      wipe_row_d   = '0;
    end else if ((wipe_state_q == WIPING) && tick_w) begin
      if (next_row_w >= ROW_LIMIT) begin
        wipe_state_d = WIPE_IDLE;
      end else begin
        wipe_row_d = next_row_w;
      end
    end

    // Rows above the wipe boundary already show the new screen.
    if ((wipe_state_q == WIPING) && !({1'b0, Y} < wipe_row_q)) begin
      colour_d = old_colour_w;
    end else begin
      colour_d = new_colour_w;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      colour_q      <= '0;
      frame_tick_q  <= 1'b0;
      wipe_active_q <= 1'b0;
      frame_count_q <= '0;
      flash_cnt_q   <= '0;
      flash_on_q    <= 1'b1;
      cur_state_q   <= 2'b00;
      old_state_q   <= 2'b00;
      wipe_row_q    <= '0;
      wipe_state_q  <= WIPE_IDLE;
    end else begin
      colour_q      <= colour_d;
      frame_tick_q  <= frame_tick_d;
      wipe_active_q <= wipe_active_d;
      frame_count_q <= frame_count_d;
      flash_cnt_q   <= flash_cnt_d;
      flash_on_q    <= flash_on_d;
      cur_state_q   <= cur_state_d;
      old_state_q   <= old_state_d;
      wipe_row_q    <= wipe_row_d;
      wipe_state_q  <= wipe_state_d;
    end
  end

  assign Colour      = colour_q;
  assign Frame_Tick  = frame_tick_q;
  assign Wipe_Active = wipe_active_q;

endmodule

`default_nettype wire

// File: tb/tb_state_screen_renderer.sv
//------------------------------------------------------------------------------
// Module      : tb_state_screen_renderer
// Description : Self-checking bench for state_screen_renderer on a small
//               16x8 screen with fast flash and wipe settings.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_state_screen_renderer;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int FF = 2;
  localparam logic [11:0] PLAY_C = 12'h5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [1:0]  ps;
  logic [11:0] cin;
  logic [11:0] colour;
  logic        frame_tick;
  logic        wipe_active;

  always #5 clk = ~clk;

  state_screen_renderer #(
    .H_RES(H), .V_RES(V), .X_W(10), .Y_W(9), .COLOUR_W(12), .FRAME_W(8),
    .IDLE_COLOUR(12'hF00), .LOSE_COLOUR(12'h00F),
    .FLASH_FRAMES(FF), .WIPE_STEP(3)
  ) dut (
    .CLK(clk), .RESET(rst), .X(x), .Y(y), .Play_State(ps),
    .Colour_in(cin), .Colour(colour), .Frame_Tick(frame_tick),
    .Wipe_Active(wipe_active)
  );

  int total = 0;
  int bad   = 0;

  // Frame counter / flash reference
  int m_fc   = 0;
  int m_fcnt = 0;
  bit m_fon  = 1'b1;

  // Per-frame captures
  logic [11:0] rc [8];
  logic [11:0] c_a;
  logic        wa_first, wa_last;
  int          ticks;
  int          f_fc;
  bit          f_fon;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    bit corner;
    corner = (x == 10'(H - 1)) && (y == 9'(V - 1));
    @(posedge clk);
    if (rst) begin
      m_fc = 0; m_fcnt = 0; m_fon = 1'b1;
    end else if (corner) begin
      m_fc++;
      if (m_fcnt == FF - 1) begin m_fcnt = 0; m_fon = !m_fon; end
      else m_fcnt++;
    end
    #1;
  endtask

  function automatic logic [11:0] exp_s(input logic [1:0] st, input int xx, input int yy,
                                        input int fc, input bit fon);
    int dx, dy;
    dx = (xx >= H / 2) ? xx - H / 2 : H / 2 - xx;
    dy = (yy >= V / 2) ? yy - V / 2 : V / 2 - yy;
    case (st)
      2'b00:   return 12'hF00;
      2'b01:   return PLAY_C;
      2'b10:   return 12'(dx + dy + (fc % 256));
      default: return fon ? 12'h00F : 12'h000;
    endcase
  endfunction

  // Scans one full frame; optionally switches Play_State at linear index sw_idx.
  task automatic scan_frame(input logic [1:0] sw_ps, input int sw_idx);
    f_fc  = m_fc;
    f_fon = m_fon;
    ticks = 0;
    for (int idx = 0; idx < H * V; idx++) begin
      x = 10'(idx % H);
      y = 9'(idx / H);
      if (idx == sw_idx) ps = sw_ps;
      step();
      if (frame_tick) ticks++;
      if (idx == 0) wa_first = wipe_active;
      if (idx % H == 0) rc[idx / H] = colour;
      if (idx == 2 * H + 10) c_a = colour;
    end
    wa_last = wipe_active;
    x = '0;
    y = '0;
  endtask

  typedef struct {
    logic [11:0] cin;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl [6];
  logic [11:0] prev;
  int tick_sum;

  initial begin
    tbl = '{
      '{12'hABC, 10'd3,  9'd1, 12'hABC},
      '{12'h123, 10'd4,  9'd1, 12'h123},
      '{12'hFFF, 10'd15, 9'd6, 12'hFFF},
      '{12'h000, 10'd0,  9'd7, 12'h000},
      '{12'h800, 10'd14, 9'd7, 12'h800},
      '{12'h00E, 10'd7,  9'd0, 12'h00E}
    };

    // Reset and Idle
    rst = 1'b1; ps = 2'b00; x = 10'd5; y = 9'd5; cin = '0;
    repeat (3) step();
    check("reset_colour", 32'(colour), 32'h000);
    check("reset_wipe", 32'(wipe_active), 32'd0);
    check("reset_tick", 32'(frame_tick), 32'd0);
    rst = 1'b0;
    step();
    check("idle_colour", 32'(colour), 32'hF00);
    check("idle_wipe", 32'(wipe_active), 32'd0);

    // Play passthrough with one-cycle latency
    ps = 2'b01; cin = PLAY_C; x = '0; y = '0;
    step();
    repeat (3) scan_frame(2'b00, -1);
    step();
    check("play_wipe_done", 32'(wipe_active), 32'd0);
    prev = PLAY_C;
    for (int i = 0; i < 6; i++) begin
      cin = tbl[i].cin; x = tbl[i].x; y = tbl[i].y;
      #1;
      check($sformatf("no_comb_path_%0d", i), 32'(colour), 32'(prev));
      step();
      check($sformatf("play_latency_%0d", i), 32'(colour), 32'(tbl[i].exp));
      prev = tbl[i].exp;
    end
    cin = PLAY_C; x = '0; y = '0;
    step();

    // Frame tick and Win pattern
    ps = 2'b10;
    step();
    tick_sum = 0;
    for (int f = 0; f < 3; f++) begin
      scan_frame(2'b00, -1);
      tick_sum += ticks;
    end
    check("tick_count_3_frames", 32'(tick_sum), 32'd3);
    step();
    check("win_wipe_done", 32'(wipe_active), 32'd0);
    scan_frame(2'b00, -1);
    check("win_tick_one", 32'(ticks), 32'd1);
    check("win_10_2", 32'(c_a), 32'(exp_s(2'b10, 10, 2, f_fc, f_fon)));
    check("win_0_0", 32'(rc[0]), 32'(exp_s(2'b10, 0, 0, f_fc, f_fon)));
    check("win_0_7", 32'(rc[7]), 32'(exp_s(2'b10, 0, 7, f_fc, f_fon)));
    scan_frame(2'b00, -1);
    check("win_10_2_next", 32'(c_a), 32'(exp_s(2'b10, 10, 2, f_fc, f_fon)));

    // Back to Idle, then Idle -> Lose wipe starting mid-frame
    ps = 2'b00;
    step();
    repeat (3) scan_frame(2'b00, -1);
    step();
    scan_frame(2'b11, 3 * H + 8);
    check("wipe_f0_row0_idle", 32'(rc[0]), 32'hF00);
    check("wipe_f0_row7_idle", 32'(rc[7]), 32'hF00);
    check("wipe_f0_active", 32'(wa_last), 32'd1);
    scan_frame(2'b00, -1);
    check("wipe_f1_row0_lose", 32'(rc[0]), 32'(exp_s(2'b11, 0, 0, f_fc, f_fon)));
    check("wipe_f1_row2_lose", 32'(rc[2]), 32'(exp_s(2'b11, 0, 2, f_fc, f_fon)));
    check("wipe_f1_row3_idle", 32'(rc[3]), 32'hF00);
    check("wipe_f1_row7_idle", 32'(rc[7]), 32'hF00);
    scan_frame(2'b00, -1);
    check("wipe_f2_row5_lose", 32'(rc[5]), 32'(exp_s(2'b11, 0, 5, f_fc, f_fon)));
    check("wipe_f2_row6_idle", 32'(rc[6]), 32'hF00);
    check("wipe_f2_active", 32'(wa_last), 32'd1);
    scan_frame(2'b00, -1);
    check("wipe_f3_inactive", 32'(wa_first), 32'd0);
    check("wipe_f3_row7_lose", 32'(rc[7]), 32'(exp_s(2'b11, 0, 7, f_fc, f_fon)));

    // Lose flash over four frames
    for (int f = 0; f < 4; f++) begin
      scan_frame(2'b00, -1);
      check($sformatf("lose_flash_f%0d", f), 32'(rc[0]),
            32'(exp_s(2'b11, 0, 0, f_fc, f_fon)));
    end

    // Restart mid-wipe: 00 -> 10, one tick later 10 -> 11
    ps = 2'b00;
    step();
    repeat (3) scan_frame(2'b00, -1);
    step();
    scan_frame(2'b10, 3 * H + 8);
    scan_frame(2'b11, 4 * H + 8);
    check("rs_row0_win", 32'(rc[0]), 32'(exp_s(2'b10, 0, 0, f_fc, f_fon)));
    check("rs_row3_idle", 32'(rc[3]), 32'hF00);
    check("rs_row6_old_win", 32'(rc[6]), 32'(exp_s(2'b10, 0, 6, f_fc, f_fon)));
    scan_frame(2'b00, -1);
    check("rs2_row1_lose", 32'(rc[1]), 32'(exp_s(2'b11, 0, 1, f_fc, f_fon)));
    check("rs2_row4_win", 32'(rc[4]), 32'(exp_s(2'b10, 0, 4, f_fc, f_fon)));
    check("rs2_row7_win", 32'(rc[7]), 32'(exp_s(2'b10, 0, 7, f_fc, f_fon)));
    check("rs2_active", 32'(wa_last), 32'd1);

    // Reset in the middle of that wipe
    rst = 1'b1;
    step();
    check("rst_mid_wipe_active", 32'(wipe_active), 32'd0);
    check("rst_mid_colour", 32'(colour), 32'h000);
    check("rst_mid_tick", 32'(frame_tick), 32'd0);
    rst = 1'b0;
    step();
    step();
    check("wipe_from_idle_after_reset", 32'(wipe_active), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
